// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer:
// funct3 op encodings, FSM state encoding, iteration count and the
// special-case result constants.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned ITER      = 32;
  localparam logic [31:0] QUOT_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic op_b_signed(input op_e o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_core.sv
// muldiv_core: unsigned radix-2 datapath shared by multiply and divide.
// Holds the hi/lo shift registers, the operand-B register and a single
// 33-bit adder/subtractor.
//   load   : capture magnitudes, clear hi, select mode (is_div)
//   step   : perform one iteration
//   hi/lo  : multiply -> {hi,lo} = 64-bit product
//            divide   -> hi = remainder, lo = quotient
module muldiv_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic            div_q;

  logic [XLEN:0] x;
  logic [XLEN:0] y;
  logic [XLEN:0] sum;
  logic [XLEN:0] mul_t;

  // Divide: x is the remainder shifted left with the next dividend bit,
  // and sum = x - b; sum[XLEN] set means the trial subtract borrowed.
  // Multiply: sum = hi + b, carry kept in sum[XLEN].
  always_comb begin
    x     = div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    y     = {1'b0, b_q};
    sum   = x + (div_q ? ~y : y) + {{XLEN{1'b0}}, div_q};
    mul_t = lo_q[0] ? sum : {1'b0, hi_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a_mag;
      b_q   <= b_mag;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        if (!sum[XLEN]) begin
          hi_q <= sum[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= x[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        // product shifts right through {hi,lo}; consumed multiplier bits fall off lo
        hi_q <= mul_t[XLEN:1];
        lo_q <= {mul_t[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit for the EX stage.
// Owns the IDLE/CALC/FIX/DONE FSM, the iteration counter, pipeline
// handshake (stall/busy/done), special-case detection and sign fix-up.
//   clk, rst (async, active-high)
//   start, op, rs1_data, rs2_data, rd_in : op issue, sampled in IDLE
//   flush                                : kill in-flight op
//   stall, busy                          : pipeline hold / unit occupied
//   done, result, rd_out                 : one-cycle completion pulse + data
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_e          state;
  logic [5:0]      cnt;
  op_e             op_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic [4:0]      rd_q;

  op_e             op_in;
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  logic [XLEN-1:0]   core_hi;
  logic [XLEN-1:0]   core_lo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_res;

  assign op_in  = op_e'(op);
  assign accept = (state == S_IDLE) && start && !flush;

  always_comb begin
    a_neg    = op_a_signed(op_in) && rs1_data[XLEN-1];
    b_neg    = op_b_signed(op_in) && rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = op_in[2] && (rs2_data == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (rs1_data == INT_MIN) && (rs2_data == '1);
    special  = div_zero || div_ovf;
  end

  always_comb begin
    special_res = '0;
    case (op_in)
      OP_DIV, OP_DIVU: special_res = div_zero ? QUOT_ONES : INT_MIN;
      OP_REM, OP_REMU: special_res = div_zero ? rs1_data : '0;
      default:         special_res = '0;
    endcase
  end

  muldiv_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && !special),
    .step   (state == S_CALC),
    .is_div (op_in[2]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Sign flags are zero for unsigned ops (and MUL, whose low word is
  // sign-agnostic), so negation only happens where the op calls for it.
  always_comb begin
    prod_s  = (a_neg_q ^ b_neg_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
    quot_s  = (a_neg_q ^ b_neg_q) ? -core_lo : core_lo;
    rem_s   = a_neg_q ? -core_hi : core_hi;
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot_s;
      OP_REM, OP_REMU:              fix_res = rem_s;
      default:                      fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= OP_MUL;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      rd_q    <= '0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            rd_q    <= rd_in;
            cnt     <= '0;
            if (special) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= special_res;
              rd_out <= rd_in;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == 6'(ITER - 1)) begin
            state <= S_FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= fix_res;
            rd_out <= rd_q;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = !rst && (accept || (state == S_CALC) || (state == S_FIX));

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .XLEN(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s, p;
    logic [63:0]        ua, ub, up;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ub_s = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin up = ua * ub;  return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE and follow it to completion.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int          lat;
    logic        got;
    logic        stall_ok;
    logic [31:0] exp_res;
    int          exp_lat;
    exp_res  = ref_result(f, a, b);
    exp_lat  = ref_latency(f, a, b);
    @(negedge clk);
    start = 1'b1; op = f; rs1_data = a; rs2_data = b; rd_in = rd;
    #1 check({tag, ".stall_issue"}, stall, 1);
    @(posedge clk);
    #1 start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    lat = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      // starts while busy must be ignored
      start = (lat >= 5 && lat < 10);
      op    = 3'($urandom);
      if (done) got = 1'b1;
      else if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, ".stall_busy_while_running"}, stall_ok, 1);
    check({tag, ".latency"}, lat, exp_lat);
    if (got) begin
      check({tag, ".result"}, result, exp_res);
      check({tag, ".rd_out"}, rd_out, rd);
      check({tag, ".stall_in_done"}, stall, 0);
      @(negedge clk);
      check({tag, ".done_one_cycle"}, {busy, done}, 2'b00);
      check({tag, ".result_hold"}, result, exp_res);
    end
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic        no_done;

    rst = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0; flush = 1'b0;
    #1;
    check("reset_outputs", {stall, busy, done, result, rd_out}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3);
    do_op("mulhu_m1",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4);
    do_op("mulh_m1",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5);
    do_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6);
    do_op("remu_div0",  3'd7, 32'd17,         32'd0,         5'd7);
    do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,         5'd8);
    do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,         5'd9);
    do_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 5'd10);
    do_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11);

    // flush in IDLE wins over start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0;
    #1 check("idle_flush_no_stall", stall, 0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("idle_flush_not_accepted", busy, 0);

    // flush at N+10 during DIVU, restart at N+11
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd7; rd_in = 5'd12;
    @(posedge clk);
    #1 start = 1'b0;
    no_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) no_done = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_no_done", {no_done, done}, 2'b10);
    check("flush_idle", busy, 0);
    do_op("after_flush", 3'd5, 32'd1000, 32'd7, 5'd13);

    // reset at N+20 during MUL
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_data = 32'd12345; rs2_data = 32'd678; rd_in = 5'd14;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1 check("midop_reset_outputs", {stall, busy, done, result, rd_out}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset_idle", {busy, done}, 2'b00);
    do_op("after_reset", 3'd0, 32'd12345, 32'd678, 5'd15);

    for (int n = 0; n < 50; n++) begin
      rf = 3'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      do_op($sformatf("rand%0d_op%0d", n, rf), rf, ra, rb, 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  M-extension op valid in EX, sampled only in IDLE.
REQ-005 SHALL have port op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data  input  32  forwarded operand A (dividend/multiplicand).
REQ-007 SHALL have port rs2_data  input  32  forwarded operand B (divisor/multiplier).
REQ-008 SHALL have port rd_in  input  5  destination register of the op.
REQ-009 SHALL have port flush  input  1  branch/jump taken, kills any in-flight op.
REQ-010 SHALL have port stall  output  1  hold IF/ID/EX pipeline registers.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-013 SHALL have port result  output  32  final result, valid only while done=1.
REQ-014 SHALL have port rd_out  output  5  latched rd_in, valid while done=1.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-016 IDLE: start=1 and flush=0 at edge N SHALL latch op, operands and rd_in, then go to CALC, or to DONE on a special case (REQ-021, REQ-022).
REQ-017 CALC SHALL run exactly 32 cycles (N+1..N+32), driven by a 6-bit counter counting 0..31; the counter SHALL be zero on CALC entry.
REQ-018 Multiply: radix-2 shift-add on operand magnitudes, 64-bit product; MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits with the signedness given by op.
REQ-019 Divide: radix-2 restoring on magnitudes, one 33-bit subtract per cycle.
REQ-020 FIX (cycle N+33) SHALL apply sign correction: quotient negated if operand signs differ (signed ops), remainder takes the dividend sign, product negated if the signed operand signs differ. DONE follows at N+34.
REQ-021 Divide by zero SHALL skip CALC and FIX, with done at N+1: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1_data.
REQ-022 Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF) SHALL likewise give done at N+1: DIV result 0x80000000, REM result 0.
REQ-023 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE; back-to-back start is accepted from the following IDLE cycle.
REQ-024 stall SHALL be combinational: high when (IDLE and start and not flush), and in CALC or FIX; low in DONE so the pipeline advances and captures result.
REQ-025 start in any state other than IDLE SHALL be ignored.
REQ-026 flush in CALC, FIX or DONE SHALL return the block to IDLE at the next edge with done=0 and result discarded; flush has priority over start.
REQ-027 result and rd_out SHALL hold their last values outside DONE; consumers gate them with done.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, counter 0, done 0, busy 0, stall 0, result 0, rd_out 0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL abandon the op with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-030 A shared package SHALL hold the op encodings, the state encoding, the constant ITER=32 and the special-case constants (all-ones quotient, INT_MIN).
REQ-031 One sub-module, muldiv_core, SHALL hold the shift/accumulate registers and the 33-bit adder/subtractor; muldiv_sequencer SHALL own the FSM, counter, handshake and sign fix-up.

Verification
REQ-032 MUL 7 x 0xFFFFFFFD, start at N -> done at N+34 with result 0xFFFFFFEB; stall high N..N+33.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE at N+34; MULH of the same operands -> 0x00000000.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> done at N+1 with result 0x80000000; REMU 17 / 0 -> done at N+1 with result 17.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM of the same operands -> 0xFFFFFFFF (-1); both at N+34.
REQ-036 flush at N+10 during DIVU -> IDLE at N+11, no done pulse; a new start at N+11 is accepted normally.
REQ-037 rst pulse at N+20 during MUL -> all outputs 0 immediately, no done; a subsequent MUL gives the correct result 34 cycles after its start.
